// File: rtl/fft_unload_ctrl_pkg.sv
// Shared definitions for the FFT result unloader: index sizing helpers,
// FSM state encoding and the radix-4 digit reversal used for the address map.
package fft_unload_ctrl_pkg;

  localparam int DEF_A_BIT = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } unload_state_t;

  // Frequency index width K and point count N for a given per-bank address width.
  function automatic int idx_width(input int a_bit);
    return a_bit + 2;
  endfunction

  function automatic int n_points(input int a_bit);
    return 1 << (a_bit + 2);
  endfunction

  // Reverse the lowest 'digits' base-4 digits of val; upper result bits are zero.
  function automatic logic [31:0] digit_rev(input logic [31:0] val, input int digits);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < digits) begin
        r = {r[29:0], val[2*i +: 2]};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_unload_fifo.sv
// Small synchronous skid FIFO between the RAM read pipe and the output port.
// First-word-fall-through: head is the oldest entry whenever valid is high.
module fft_unload_fifo
  import fft_unload_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_pop  = pop && (count_reg != '0);
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push = push && ((count_reg != CNT_W'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end
      if (do_pop) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  assign head  = mem[rd_ptr_reg];
  assign valid = (count_reg != '0);
  assign count = count_reg;

endmodule

// File: rtl/fft_unload_ctrl.sv
// Streams the N results of one FFT out of the 4-bank result RAM in natural
// frequency order, with credit-based read issue so the skid FIFO cannot overflow.
module fft_unload_ctrl
  import fft_unload_ctrl_pkg::*;
#(
  parameter int A_BIT  = DEF_A_BIT,
  parameter int D_BIT  = 16,
  parameter int RD_LAT = 2,
  parameter int FIFO_D = 4
) (
  input  logic               iCLK,
  input  logic               iRESET,
  input  logic               iRDY,
  input  logic               iSOURCE,
  input  logic               iABORT,
  output logic               oRD_EN,
  output logic               oRD_SET,
  output logic [1:0]         oRD_BANK,
  output logic [A_BIT-1:0]   oADDR_RD,
  input  logic [2*D_BIT-1:0] iQ_0,
  input  logic [2*D_BIT-1:0] iQ_1,
  input  logic [2*D_BIT-1:0] iQ_2,
  input  logic [2*D_BIT-1:0] iQ_3,
  output logic [2*D_BIT-1:0] oDATA,
  output logic               oVALID,
  input  logic               iREADY,
  output logic               oLAST,
  output logic               oBUSY,
  output logic               oDONE
);

  localparam int K     = idx_width(A_BIT);
  localparam int N     = n_points(A_BIT);
  localparam int W     = 2 * D_BIT;
  localparam int FCW   = $clog2(FIFO_D + 1);
  localparam int CW    = $clog2(FIFO_D + RD_LAT + 2) + 1;

  unload_state_t   state_reg;
  logic            rdy_d_reg;
  logic [K-1:0]    k_reg;
  logic [K-1:0]    out_cnt_reg;
  logic            rd_en_reg;
  logic            rd_set_reg;
  logic [1:0]      rd_bank_reg;
  logic [A_BIT-1:0] rd_addr_reg;
  logic            busy_reg;
  logic            done_reg;

  logic [RD_LAT-1:0] pipe_valid_reg;
  logic [1:0]        pipe_bank_reg [RD_LAT];

  logic            rdy_rise;
  logic [K-1:0]    rev_k;
  logic [W-1:0]    q_sel;
  logic            fifo_push;
  logic            fifo_pop;
  logic            fifo_valid;
  logic [W-1:0]    fifo_head;
  logic [FCW-1:0]  fifo_cnt;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   credit;
  logic            credit_ok;

  assign rdy_rise = iRDY & ~rdy_d_reg;
  assign rev_k    = K'(digit_rev(32'(k_reg), K / 2));

  // Outstanding reads: the strobe on the bus now, the RAM pipe and the FIFO.
  // A pop this cycle frees a slot, which keeps a full-rate stream going.
  always_comb begin
    inflight = CW'(rd_en_reg);
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + CW'(pipe_valid_reg[i]);
    end
    credit = inflight + CW'(fifo_cnt) - CW'(fifo_pop);
  end

  assign credit_ok = (credit < CW'(FIFO_D));

  // Valid/bank shift register aligned with the RAM read latency.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      pipe_valid_reg <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_bank_reg[i] <= '0;
      end
    end else begin
      pipe_valid_reg[0] <= rd_en_reg & ~iABORT;
      pipe_bank_reg[0]  <= rd_bank_reg;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_valid_reg[i] <= pipe_valid_reg[i-1] & ~iABORT;
        pipe_bank_reg[i]  <= pipe_bank_reg[i-1];
      end
    end
  end

  always_comb begin
    q_sel = iQ_0;
    case (pipe_bank_reg[RD_LAT-1])
      2'd1:    q_sel = iQ_1;
      2'd2:    q_sel = iQ_2;
      2'd3:    q_sel = iQ_3;
      default: q_sel = iQ_0;
    endcase
  end

  assign fifo_push = pipe_valid_reg[RD_LAT-1] & ~iABORT;
  assign fifo_pop  = fifo_valid & iREADY;

  fft_unload_fifo #(
    .DEPTH (FIFO_D),
    .WIDTH (W),
    .CNT_W (FCW)
  ) u_fifo (
    .clk       (iCLK),
    .rst_n     (iRESET),
    .flush     (iABORT),
    .push      (fifo_push),
    .push_data (q_sel),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .valid     (fifo_valid),
    .count     (fifo_cnt)
  );

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state_reg   <= ST_IDLE;
      rdy_d_reg   <= 1'b0;
      k_reg       <= '0;
      out_cnt_reg <= '0;
      rd_en_reg   <= 1'b0;
      rd_set_reg  <= 1'b0;
      rd_bank_reg <= '0;
      rd_addr_reg <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      rdy_d_reg <= iRDY;
      done_reg  <= 1'b0;
      if (iABORT) begin
        state_reg   <= ST_IDLE;
        rd_en_reg   <= 1'b0;
        busy_reg    <= 1'b0;
        k_reg       <= '0;
        out_cnt_reg <= '0;
      end else begin
        if (fifo_pop) begin
          out_cnt_reg <= out_cnt_reg + K'(1);
        end
        case (state_reg)
          ST_IDLE: begin
            rd_en_reg <= 1'b0;
            if (rdy_rise) begin
              state_reg   <= ST_RUN;
              busy_reg    <= 1'b1;
              rd_set_reg  <= iSOURCE;
              k_reg       <= '0;
              out_cnt_reg <= '0;
            end
          end
          ST_RUN: begin
            if (credit_ok) begin
              rd_en_reg   <= 1'b1;
              rd_bank_reg <= rev_k[K-1:K-2];
              rd_addr_reg <= rev_k[A_BIT-1:0];
              if (k_reg == K'(N - 1)) begin
                state_reg <= ST_DRAIN;
              end else begin
                k_reg <= k_reg + K'(1);
              end
            end else begin
              rd_en_reg <= 1'b0;
            end
          end
          ST_DRAIN: begin
            rd_en_reg <= 1'b0;
            // All reads are issued, so the final pop leaves pipe and FIFO empty.
            if (fifo_pop && out_cnt_reg == K'(N - 1)) begin
              state_reg <= ST_IDLE;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end
          end
          default: begin
            state_reg <= ST_IDLE;
            rd_en_reg <= 1'b0;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign oRD_EN   = rd_en_reg;
  assign oRD_SET  = rd_set_reg;
  assign oRD_BANK = rd_bank_reg;
  assign oADDR_RD = rd_addr_reg;
  assign oVALID   = fifo_valid;
  assign oDATA    = fifo_valid ? fifo_head : '0;
  assign oLAST    = fifo_valid && (out_cnt_reg == K'(N - 1));
  assign oBUSY    = busy_reg;
  assign oDONE    = done_reg;

endmodule

// File: tb/tb_fft_unload_ctrl.sv
// Self-checking bench for fft_unload_ctrl: RAM model returning {set,bank,addr},
// a reference model of the unload order, and directed scenarios.
module tb_fft_unload_ctrl;

  localparam int A_BIT  = 10;
  localparam int D_BIT  = 16;
  localparam int RD_LAT = 2;
  localparam int FIFO_D = 4;
  localparam int K      = A_BIT + 2;
  localparam int N      = 4096;

  logic        clk = 1'b0;
  logic        rst_n, rdy, src, abort, ready;
  logic        rd_en, rd_set, valid, last, busy, done;
  logic [1:0]  rd_bank;
  logic [A_BIT-1:0] rd_addr;
  logic [31:0] q0, q1, q2, q3, data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fft_unload_ctrl #(.A_BIT(A_BIT), .D_BIT(D_BIT), .RD_LAT(RD_LAT), .FIFO_D(FIFO_D)) dut (
    .iCLK(clk), .iRESET(rst_n), .iRDY(rdy), .iSOURCE(src), .iABORT(abort),
    .oRD_EN(rd_en), .oRD_SET(rd_set), .oRD_BANK(rd_bank), .oADDR_RD(rd_addr),
    .iQ_0(q0), .iQ_1(q1), .iQ_2(q2), .iQ_3(q3),
    .oDATA(data), .oVALID(valid), .iREADY(ready), .oLAST(last),
    .oBUSY(busy), .oDONE(done)
  );

  // RAM model: every bank answers {set, bank, addr} RD_LAT cycles after the strobe.
  logic [RD_LAT-1:0] s_v = '0;
  logic [RD_LAT-1:0] s_set = '0;
  logic [A_BIT-1:0]  s_addr [RD_LAT];

  always @(posedge clk) begin
    s_v[0]    <= rd_en;
    s_set[0]  <= rd_set;
    s_addr[0] <= rd_addr;
    for (int i = 1; i < RD_LAT; i++) begin
      s_v[i]    <= s_v[i-1];
      s_set[i]  <= s_set[i-1];
      s_addr[i] <= s_addr[i-1];
    end
  end

  assign q0 = s_v[RD_LAT-1] ? {19'd0, s_set[RD_LAT-1], 2'd0, s_addr[RD_LAT-1]} : 32'hDEAD_BEEF;
  assign q1 = s_v[RD_LAT-1] ? {19'd0, s_set[RD_LAT-1], 2'd1, s_addr[RD_LAT-1]} : 32'hDEAD_BEEF;
  assign q2 = s_v[RD_LAT-1] ? {19'd0, s_set[RD_LAT-1], 2'd2, s_addr[RD_LAT-1]} : 32'hDEAD_BEEF;
  assign q3 = s_v[RD_LAT-1] ? {19'd0, s_set[RD_LAT-1], 2'd3, s_addr[RD_LAT-1]} : 32'hDEAD_BEEF;

  // Base-4 digit reversal over K/2 digits, done arithmetically.
  function automatic int rev4(input int k);
    int r = 0;
    int v = k;
    for (int d = 0; d < K / 2; d++) begin
      r = r * 4 + (v % 4);
      v = v / 4;
    end
    return r;
  endfunction

  function automatic logic [31:0] exp_word(input logic s, input int k);
    return (32'(s) << K) | 32'(rev4(k));
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state, owned by the monitor (exp_set is written only by the stimulus).
  logic        exp_set = 1'b0;
  int          cyc = 0, issued = 0, xfer_idx = 0, done_cnt = 0;
  int          first_rd = -1, first_val = -1, first_xfer = -1, last_xfer = -1;
  int          run_first_rd, run_first_val, run_first_xfer, run_last_xfer, run_xfers;
  logic [31:0] data1, run_data1, held_data;
  logic        held = 0, held_last = 0, prev_last_xfer = 0, prev_done = 0;
  int          rd_log [N];

  task automatic clear_run();
    issued = 0; xfer_idx = 0;
    first_rd = -1; first_val = -1; first_xfer = -1; last_xfer = -1;
    held = 0; prev_last_xfer = 0;
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      clear_run();
      prev_done = 0;
    end else begin
      if (rd_en) begin
        check("rd_within_n", issued < N, 1);
        if (issued < N) begin
          check("rd_map", {rd_bank, rd_addr}, 64'(rev4(issued)));
          check("rd_set", rd_set, exp_set);
          rd_log[issued] = int'({rd_bank, rd_addr});
        end
        if (first_rd < 0) first_rd = cyc;
        issued++;
      end
      check("outstanding_le_depth", (issued - xfer_idx) <= FIFO_D, 1);
      if (valid && first_val < 0) first_val = cyc;
      if (held) begin
        check("hold_valid", valid, 1);
        check("hold_data", data, held_data);
        check("hold_last", last, held_last);
      end
      check("last", last, valid && (xfer_idx == N - 1));
      check("done", done, prev_last_xfer);
      if (prev_done) check("busy_after_done", busy, 0);
      prev_done = done;
      prev_last_xfer = 0;
      if (valid && ready) begin
        check("xfer_within_n", xfer_idx < N, 1);
        check("data", data, exp_word(exp_set, xfer_idx));
        if (first_xfer < 0) first_xfer = cyc;
        last_xfer = cyc;
        if (xfer_idx == 1) data1 = data;
        if (xfer_idx == N - 1) prev_last_xfer = 1;
        xfer_idx++;
      end
      held = valid && !ready;
      held_data = data;
      held_last = last;
      if (done) begin
        run_first_rd = first_rd; run_first_val = first_val;
        run_first_xfer = first_xfer; run_last_xfer = last_xfer;
        run_xfers = xfer_idx; run_data1 = data1;
        done_cnt++;
        clear_run();
      end
      if (abort) clear_run();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic s);
    exp_set = s;
    src = s;
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
  endtask

  task automatic wait_done(input int budget, input int mode);
    int start_cnt = done_cnt;
    bit got = 0;
    for (int i = 0; i < budget && !got; i++) begin
      ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      if (done_cnt != start_cnt) got = 1;
    end
    ready = 1'b1;
    check("done_within_budget", got, 1);
  endtask

  task automatic wait_xfers(input int target, input int budget);
    bit got = 0;
    for (int i = 0; i < budget && !got; i++) begin
      tick();
      if (xfer_idx >= target) got = 1;
    end
    check("xfers_within_budget", got, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_last"}, last, 0);
    check({tag, "_data"}, data, 0);
    check({tag, "_bank_addr"}, {rd_set, rd_bank, rd_addr}, 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc;
    rst_n = 1'b0; rdy = 1'b0; src = 1'b0; abort = 1'b0; ready = 1'b1;
    repeat (3) tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) tick();

    // Full run at full rate; pins map and latency against literals.
    start_run(1'b0);
    wait_done(6000, 0);
    check("full_xfers", run_xfers, N);
    check("full_span", run_last_xfer - run_first_xfer, 4095);
    check("first_valid_latency", run_first_val - run_first_rd, 3);
    check("map_k0", rd_log[0], 12'h000);
    check("map_k1", rd_log[1], 12'h400);
    check("map_k2", rd_log[2], 12'h800);
    check("map_k4", rd_log[4], 12'h100);
    check("map_k4095", rd_log[4095], 12'hFFF);
    check("data_k1", run_data1, 32'h0000_0400);
    tick();
    check("idle_busy", busy, 0);

    // Random backpressure.
    start_run(1'b0);
    wait_done(20000, 1);
    check("random_xfers", run_xfers, N);

    // Long stall: reads stop at FIFO_D outstanding, then resume gap-free.
    start_run(1'b0);
    wait_xfers(100, 1000);
    ready = 1'b0;
    repeat (20) tick();
    check("stall_rd_en", rd_en, 0);
    check("stall_outstanding", issued - xfer_idx, FIFO_D);
    check("stall_valid", valid, 1);
    ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      check("resume_no_gap", valid, 1);
      tick();
    end
    wait_done(6000, 0);
    check("stall_xfers", run_xfers, N);

    // Abort at transfer #1000.
    start_run(1'b0);
    wait_xfers(1000, 2000);
    dc = done_cnt;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_valid", valid, 0);
    check("abort_busy", busy, 0);
    repeat (20) tick();
    check("abort_no_done", done_cnt, dc);
    check("abort_idle_rd", rd_en, 0);

    // Abort together with an iRDY rise: stays idle.
    abort = 1'b1; rdy = 1'b1;
    tick();
    abort = 1'b0;
    repeat (3) tick();
    check("abort_rise_busy", busy, 0);
    check("abort_rise_rd", rd_en, 0);
    rdy = 1'b0;
    tick();

    start_run(1'b0);
    wait_done(6000, 0);
    check("restart_xfers", run_xfers, N);
    check("restart_data_k1", run_data1, 32'h0000_0400);

    // Set B, with iSOURCE toggled and an iRDY glitch mid-run.
    start_run(1'b1);
    wait_xfers(500, 1000);
    src = 1'b0;
    rdy = 1'b1; tick();
    rdy = 1'b0; tick();
    check("glitch_busy", busy, 1);
    check("glitch_set", rd_set, 1);
    wait_done(6000, 0);
    check("setb_xfers", run_xfers, N);
    check("setb_data_k1", run_data1, 32'h0000_1400);

    // Asynchronous reset mid-run.
    start_run(1'b0);
    wait_xfers(300, 1000);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    start_run(1'b0);
    wait_done(6000, 0);
    check("post_reset_xfers", run_xfers, N);

    repeat (5) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
